// File: rtl/avr_cpu_regfile_arbiter.sv
// Shares the single register-bank write port between CPU writeback and the debug port.
// Word (pair) writes go out as two byte writes: the high byte to the even register, then the low byte.
module avr_cpu_regfile_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_word,
  input  logic [4:0]  i_cpu_addr,
  input  logic [15:0] i_cpu_data,
  output logic        o_cpu_ack,
  input  logic        i_dbg_req,
  input  logic [4:0]  i_dbg_addr,
  input  logic [7:0]  i_dbg_data,
  output logic        o_dbg_ack,
  output logic        o_rf_write,
  output logic [4:0]  o_rf_addr,
  output logic [7:0]  o_rf_in,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, WR_BYTE, WR_HI, WR_LO} state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic [3:0] r_starveCnt;
  logic [4:0] r_loAddr;
  logic [7:0] r_loData;
  logic       w_dbgForce;

  assign w_dbgForce = i_dbg_req && (r_starveCnt == LP_LIMIT);

  // Outputs are loaded at the transition into each write state, so every write state
  // presents its bank write (and ack) for exactly the one cycle it occupies.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_starveCnt <= '0;
      r_loAddr    <= '0;
      r_loData    <= '0;
      o_rf_write  <= 1'b0;
      o_rf_addr   <= '0;
      o_rf_in     <= '0;
      o_cpu_ack   <= 1'b0;
      o_dbg_ack   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_rf_write <= 1'b0;
          o_cpu_ack  <= 1'b0;
          o_dbg_ack  <= 1'b0;
          o_busy     <= 1'b0;
          if (w_dbgForce) begin
            r_starveCnt <= '0;
            o_rf_write  <= 1'b1;
            o_rf_addr   <= i_dbg_addr;
            o_rf_in     <= i_dbg_data;
            o_dbg_ack   <= 1'b1;
            o_busy      <= 1'b1;
            r_state     <= WR_BYTE;
          end else if (i_cpu_req) begin
            if (!i_dbg_req)
              r_starveCnt <= '0;
            else if (r_starveCnt != LP_LIMIT)
              r_starveCnt <= r_starveCnt + 4'd1;
            o_rf_write <= 1'b1;
            o_busy     <= 1'b1;
            if (i_cpu_word) begin
              o_rf_addr <= {i_cpu_addr[4:1], 1'b0};
              o_rf_in   <= i_cpu_data[15:8];
              r_loAddr  <= {i_cpu_addr[4:1], 1'b1};
              r_loData  <= i_cpu_data[7:0];
              r_state   <= WR_HI;
            end else begin
              o_rf_addr <= i_cpu_addr;
              o_rf_in   <= i_cpu_data[7:0];
              o_cpu_ack <= 1'b1;
              r_state   <= WR_BYTE;
            end
          end else if (i_dbg_req) begin
            r_starveCnt <= '0;
            o_rf_write  <= 1'b1;
            o_rf_addr   <= i_dbg_addr;
            o_rf_in     <= i_dbg_data;
            o_dbg_ack   <= 1'b1;
            o_busy      <= 1'b1;
            r_state     <= WR_BYTE;
          end else begin
            r_starveCnt <= '0;
          end
        end
        WR_HI: begin
          o_rf_write <= 1'b1;
          o_rf_addr  <= r_loAddr;
          o_rf_in    <= r_loData;
          o_cpu_ack  <= 1'b1;
          o_busy     <= 1'b1;
          r_state    <= WR_LO;
        end
        default: begin
          o_rf_write <= 1'b0;
          o_cpu_ack  <= 1'b0;
          o_dbg_ack  <= 1'b0;
          o_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_cpu_regfile_arbiter.sv
// Directed bench for avr_cpu_regfile_arbiter; expected bank writes are queued when requests
// are driven and popped by a negedge monitor whenever the bank port or an ack is active.
module tb_avr_cpu_regfile_arbiter;

  logic        clk;
  logic        rstN;
  logic        cpuReq;
  logic        cpuWord;
  logic [4:0]  cpuAddr;
  logic [15:0] cpuData;
  logic        cpuAck;
  logic        dbgReq;
  logic [4:0]  dbgAddr;
  logic [7:0]  dbgData;
  logic        dbgAck;
  logic        rfWrite;
  logic [4:0]  rfAddr;
  logic [7:0]  rfIn;
  logic        busy;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
    logic       cpuAck;
    logic       dbgAck;
  } wr_t;

  wr_t        sbQ[$];
  logic [7:0] bank [32];
  int         compared   = 0;
  int         mismatched = 0;

  avr_cpu_regfile_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_cpu_req  (cpuReq),
    .i_cpu_word (cpuWord),
    .i_cpu_addr (cpuAddr),
    .i_cpu_data (cpuData),
    .o_cpu_ack  (cpuAck),
    .i_dbg_req  (dbgReq),
    .i_dbg_addr (dbgAddr),
    .i_dbg_data (dbgData),
    .o_dbg_ack  (dbgAck),
    .o_rf_write (rfWrite),
    .o_rf_addr  (rfAddr),
    .o_rf_in    (rfIn),
    .o_busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWord, input logic [4:0] cAddr,
                               input logic [15:0] cData, input logic dReq,
                               input logic [4:0] dAddr, input logic [7:0] dData);
    cpuReq  = cReq;
    cpuWord = cWord;
    cpuAddr = cAddr;
    cpuData = cData;
    dbgReq  = dReq;
    dbgAddr = dAddr;
    dbgData = dData;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [7:0] d, input logic ca, input logic da);
    wr_t e;
    e.addr   = a;
    e.data   = d;
    e.cpuAck = ca;
    e.dbgAck = da;
    sbQ.push_back(e);
  endtask

  // Any bank write or ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rfWrite || cpuAck || dbgAck) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnexpected", {rfWrite, rfAddr, rfIn, cpuAck, dbgAck}, 16'h0000);
      end else begin
        wr_t e;
        e = sbQ.pop_front();
        checkOutput("sbWrite", {rfWrite, rfAddr, rfIn, cpuAck, dbgAck},
                    {1'b1, e.addr, e.data, e.cpuAck, e.dbgAck});
      end
      if (rfWrite) bank[rfAddr] = rfIn;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0]  savedOdd;
    logic [15:0] wordTbl [2];
    logic [4:0]  addrTbl [2];
    wordTbl[0] = 16'h5678; addrTbl[0] = 5'd30;
    wordTbl[1] = 16'h1234; addrTbl[1] = 5'd31;
    for (int i = 0; i < 32; i++) bank[i] = 8'h00;

    rstN = 1'b0;
    applyStimulus(0, 0, 5'd0, 16'h0, 0, 5'd0, 8'h0);
    tick();
    tick();
    checkOutput("rstWrite", 16'(rfWrite), 16'h0);
    checkOutput("rstAddr",  16'(rfAddr),  16'h0);
    checkOutput("rstIn",    16'(rfIn),    16'h0);
    checkOutput("rstAcks",  16'({cpuAck, dbgAck}), 16'h0);
    checkOutput("rstBusy",  16'(busy),    16'h0);
    rstN = 1'b1;
    tick();

    // CPU byte write: one write plus ack in the cycle after the request
    applyStimulus(1, 0, 5'd5, 16'h00A5, 0, 5'd0, 8'h0);
    expectWrite(5'd5, 8'hA5, 1, 0);
    tick();
    checkOutput("byteN1", {rfWrite, rfAddr, rfIn, cpuAck, dbgAck}, {1'b1, 5'd5, 8'hA5, 1'b1, 1'b0});
    checkOutput("byteN1Busy", 16'(busy), 16'h1);
    cpuReq = 1'b0;
    tick();
    checkOutput("byteN2", {rfWrite, cpuAck, dbgAck, busy}, 16'h0);
    checkOutput("byteHoldAddr", {rfAddr, rfIn}, {5'd5, 8'hA5});

    // CPU word writes: even register takes the high byte, address bit 0 ignored
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 1, addrTbl[k], wordTbl[k], 0, 5'd0, 8'h0);
      expectWrite(5'd30, wordTbl[k][15:8], 0, 0);
      expectWrite(5'd31, wordTbl[k][7:0], 1, 0);
      tick();
      checkOutput("wordHi", {rfWrite, rfAddr, rfIn, cpuAck, dbgAck}, {1'b1, 5'd30, wordTbl[k][15:8], 2'b00});
      tick();
      checkOutput("wordLo", {rfWrite, rfAddr, rfIn, cpuAck, dbgAck}, {1'b1, 5'd31, wordTbl[k][7:0], 2'b10});
      cpuReq = 1'b0;
      tick();
      checkOutput("wordIdle", {rfWrite, cpuAck, busy}, 16'h0);
      checkOutput("wordZ", {bank[30], bank[31]}, wordTbl[k]);
    end

    // Contention: CPU first, debug two cycles after the CPU ack
    applyStimulus(1, 0, 5'd7, 16'h0011, 1, 5'd3, 8'h7E);
    expectWrite(5'd7, 8'h11, 1, 0);
    expectWrite(5'd3, 8'h7E, 0, 1);
    tick();
    checkOutput("contCpu", {cpuAck, dbgAck}, 16'h2);
    cpuReq = 1'b0;
    tick();
    checkOutput("contGap", {rfWrite, cpuAck, dbgAck}, 16'h0);
    tick();
    checkOutput("contDbg", {rfWrite, rfAddr, rfIn, cpuAck, dbgAck}, {1'b1, 5'd3, 8'h7E, 2'b01});
    dbgReq = 1'b0;
    tick();
    checkOutput("contBank", 16'(bank[3]), 16'h7E);

    // Starvation: four CPU grants, then debug is forced; second round proves the counter restarted
    applyStimulus(1, 0, 5'd10, 16'h0020, 1, 5'd9, 8'h99);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        cpuData = 16'(8'h20 + r * 4 + i);
        expectWrite(5'd10, 8'(8'h20 + r * 4 + i), 1, 0);
        tick();
        checkOutput("starveCpu", {cpuAck, dbgAck}, 16'h2);
        tick();
      end
      expectWrite(5'd9, 8'h99, 0, 1);
      tick();
      checkOutput("starveDbg", {cpuAck, dbgAck}, 16'h1);
      tick();
    end
    cpuReq = 1'b0;
    dbgReq = 1'b0;
    tick();

    // Reset during the low-byte cycle of a word write
    savedOdd = bank[21];
    applyStimulus(1, 1, 5'd20, 16'hC3D4, 0, 5'd0, 8'h0);
    expectWrite(5'd20, 8'hC3, 0, 0);
    tick();
    checkOutput("midHi", {rfWrite, rfAddr, rfIn}, {1'b1, 5'd20, 8'hC3});
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstOut", {rfWrite, rfAddr, rfIn, cpuAck, dbgAck, busy}, 16'h0);
    cpuReq = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    checkOutput("midEven", 16'(bank[20]), 16'hC3);
    checkOutput("midOdd", 16'(bank[21]), 16'(savedOdd));
    tick();

    // Request held one cycle past the ack yields exactly one more grant
    applyStimulus(1, 0, 5'd12, 16'h0055, 0, 5'd0, 8'h0);
    expectWrite(5'd12, 8'h55, 1, 0);
    expectWrite(5'd12, 8'h66, 1, 0);
    tick();
    checkOutput("heldAck1", {rfIn, cpuAck}, {8'h55, 1'b1});
    cpuData = 16'h0066;
    tick();
    checkOutput("heldIdle", {rfWrite, cpuAck}, 16'h0);
    tick();
    checkOutput("heldAck2", {rfIn, cpuAck}, {8'h66, 1'b1});
    cpuReq = 1'b0;
    tick();
    tick();
    checkOutput("heldQuiet", {rfWrite, cpuAck, busy}, 16'h0);
    tick();
    checkOutput("sbEmpty", 16'(sbQ.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
